// File: rtl/fifo_ack_ctrl.sv
// fifo_ack_ctrl: occupancy flags and round-robin four-phase write/read grant control for a FIFO
// Ports: wptr_i/rptr_i binary pointers with wrap MSB; wreq_i/rreq_i four-phase requests;
//   widle_i/ridle_i idle codes forming the threshold mode; wack_o/rack_o registered acks;
//   wfull_o/remty_o/level_o registered occupancy; err_o sticky corrupt-pointer or illegal-mode flag.
module fifo_ack_ctrl #(
  parameter int ADDRSIZE = 10,
  parameter int WTH0 = 560,
  parameter int WTH1 = 792,
  parameter int WTH2 = 95,
  parameter int WTH3 = 560,
  parameter int WTH4 = 1,
  parameter int WTH5 = 327,
  parameter int RTH  = 1,
  parameter int RTH4 = 274
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [ADDRSIZE:0]   wptr_i,
  input  logic [ADDRSIZE:0]   rptr_i,
  input  logic                wreq_i,
  input  logic                rreq_i,
  input  logic [1:0]          widle_i,
  input  logic                ridle_i,
  output logic                wack_o,
  output logic                rack_o,
  output logic                wfull_o,
  output logic                remty_o,
  output logic [ADDRSIZE:0]   level_o,
  output logic                err_o
);
  localparam logic [ADDRSIZE:0] FULL = {1'b1, {ADDRSIZE{1'b0}}};
  typedef enum logic [1:0] {IDLE, WGRANT, RGRANT} state_t;
  state_t            state_q;
  logic              last_q;
  logic              wack_q, rack_q, wfull_q, remty_q, err_q, err_d;
  logic [ADDRSIZE:0] level_q, lvl, space;
  logic [2:0]        mode;
  logic [31:0]       wth, rth;
  logic              bad, illegal, gate, wok, rok;
  assign lvl     = wptr_i - rptr_i;
  assign space   = FULL - lvl;
  assign bad     = lvl > FULL;
  assign mode    = {widle_i, ridle_i};
  assign illegal = mode[2] & mode[1];
  always_comb begin
    wth = mode == 3'b000 ? WTH0 :
          mode == 3'b001 ? WTH1 :
          mode == 3'b010 ? WTH2 :
          mode == 3'b011 ? WTH3 :
          mode == 3'b100 ? WTH4 :
          mode == 3'b101 ? WTH5 : 32'hFFFF_FFFF;
    rth = mode == 3'b100 ? RTH4 : RTH;
  end
  // corrupt pointers or an illegal mode block grants in the very cycle they appear
  assign gate  = ~err_q & ~bad & ~illegal;
  assign wok   = wreq_i & gate & (32'(space) >= wth);
  assign rok   = rreq_i & gate & (32'(lvl) >= rth);
  // the mode is only sampled in IDLE, so an illegal code during a grant is ignored
  assign err_d = err_q | bad | (illegal & (state_q == IDLE));
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      last_q  <= 1'b0;
      wack_q  <= 1'b0;
      rack_q  <= 1'b0;
      wfull_q <= 1'b0;
      remty_q <= 1'b1;
      level_q <= '0;
      err_q   <= 1'b0;
    end else begin
      level_q <= lvl;
      wfull_q <= lvl >= FULL;
      remty_q <= lvl == '0;
      err_q   <= err_d;
      if (state_q == IDLE) begin
        // last_q=1 means write won last, so a tie goes to read
        if (wok & (~rok | ~last_q)) begin
          state_q <= WGRANT;
          wack_q  <= 1'b1;
          last_q  <= 1'b1;
        end else if (rok) begin
          state_q <= RGRANT;
          rack_q  <= 1'b1;
          last_q  <= 1'b0;
        end
      end else if (state_q == WGRANT && !wreq_i) begin
        state_q <= IDLE;
        wack_q  <= 1'b0;
      end else if (state_q == RGRANT && !rreq_i) begin
        state_q <= IDLE;
        rack_q  <= 1'b0;
      end
    end
  end
  assign wack_o  = wack_q;
  assign rack_o  = rack_q;
  assign wfull_o = wfull_q;
  assign remty_o = remty_q;
  assign level_o = level_q;
  assign err_o   = err_q;
endmodule

// File: tb/tb_fifo_ack_ctrl.sv
// tb_fifo_ack_ctrl: directed self-checking bench for fifo_ack_ctrl
module tb_fifo_ack_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [10:0] wptr = '0, rptr = '0;
  logic        wreq = 1'b0, rreq = 1'b0;
  logic [1:0]  widle = 2'b00;
  logic        ridle = 1'b0;
  logic        wack, rack, wfull, remty, err;
  logic [10:0] level;
  int checks = 0;
  int errors = 0;
  fifo_ack_ctrl dut (
    .clk(clk), .rst(rst), .wptr_i(wptr), .rptr_i(rptr), .wreq_i(wreq), .rreq_i(rreq),
    .widle_i(widle), .ridle_i(ridle), .wack_o(wack), .rack_o(rack), .wfull_o(wfull),
    .remty_o(remty), .level_o(level), .err_o(err)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
    chk("ack_mutex", 32'(wack & rack), 0);
  endtask
  initial begin
    tick();
    chk("rst_wack", 32'(wack), 0);
    chk("rst_rack", 32'(rack), 0);
    chk("rst_wfull", 32'(wfull), 0);
    chk("rst_remty", 32'(remty), 1);
    chk("rst_level", 32'(level), 0);
    chk("rst_err", 32'(err), 0);
    rst = 1'b0;
    tick();
    chk("idle_remty", 32'(remty), 1);
    chk("idle_wack", 32'(wack), 0);
    wreq = 1'b1;
    tick();
    chk("t1_wack_rise", 32'(wack), 1);
    tick();
    chk("t1_wack_hold", 32'(wack), 1);
    wreq = 1'b0;
    tick();
    chk("t1_wack_fall", 32'(wack), 0);
    wptr = 11'h1D0;
    wreq = 1'b1;
    tick();
    chk("t2_space560_wack", 32'(wack), 1);
    chk("t2_level464", 32'(level), 464);
    chk("t2_remty", 32'(remty), 0);
    wreq = 1'b0;
    tick();
    chk("t2_wack_fall", 32'(wack), 0);
    wptr = 11'h1D1;
    wreq = 1'b1;
    tick();
    chk("t2_space559_nowack", 32'(wack), 0);
    tick();
    chk("t2_space559_wait", 32'(wack), 0);
    chk("t2_wait_noerr", 32'(err), 0);
    rptr = 11'h001;
    tick();
    chk("t2_space560_late_wack", 32'(wack), 1);
    wreq = 1'b0;
    tick();
    wptr = 11'h400;
    rptr = 11'h000;
    widle = 2'b10;
    wreq = 1'b1;
    tick();
    chk("t3_wfull", 32'(wfull), 1);
    chk("t3_full_nowack", 32'(wack), 0);
    chk("t3_level1024", 32'(level), 11'h400);
    wreq = 1'b0;
    wptr = 11'h002;
    rptr = 11'h7FE;
    tick();
    chk("t3_wrap_level4", 32'(level), 4);
    chk("t3_wrap_notfull", 32'(wfull), 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    wptr = 11'h12C;
    rptr = 11'h000;
    wreq = 1'b1;
    rreq = 1'b1;
    tick();
    chk("t4_first_wack", 32'(wack), 1);
    chk("t4_first_norack", 32'(rack), 0);
    wreq = 1'b0;
    tick();
    chk("t4_wack_fall", 32'(wack), 0);
    chk("t4_rack_still0", 32'(rack), 0);
    wreq = 1'b1;
    tick();
    chk("t4_rr_rack", 32'(rack), 1);
    chk("t4_rr_nowack", 32'(wack), 0);
    wreq = 1'b0;
    rreq = 1'b0;
    tick();
    chk("t4_rack_fall", 32'(rack), 0);
    wptr = 11'h111;
    rreq = 1'b1;
    tick();
    chk("t5_lvl273_norack", 32'(rack), 0);
    tick();
    chk("t5_lvl273_wait", 32'(rack), 0);
    wptr = 11'h112;
    tick();
    chk("t5_lvl274_rack", 32'(rack), 1);
    rreq = 1'b0;
    tick();
    chk("t5_rack_fall", 32'(rack), 0);
    widle = 2'b00;
    ridle = 1'b1;
    wptr = 11'h001;
    rreq = 1'b1;
    tick();
    chk("t5_mode1_lvl1_rack", 32'(rack), 1);
    rreq = 1'b0;
    tick();
    widle = 2'b11;
    ridle = 1'b1;
    wreq = 1'b1;
    tick();
    chk("t6_illegal_err", 32'(err), 1);
    chk("t6_illegal_nowack", 32'(wack), 0);
    widle = 2'b00;
    ridle = 1'b0;
    tick();
    chk("t6_err_sticky", 32'(err), 1);
    chk("t6_err_blocks_wack", 32'(wack), 0);
    wreq = 1'b0;
    rst = 1'b1;
    #1;
    chk("t6_rst_clears_err", 32'(err), 0);
    tick();
    rst = 1'b0;
    wptr = 11'h000;
    rptr = 11'h000;
    wreq = 1'b1;
    tick();
    chk("t6_wack_before_rst", 32'(wack), 1);
    #2;
    rst = 1'b1;
    #1;
    chk("t6_async_rst_wack", 32'(wack), 0);
    rst = 1'b0;
    wreq = 1'b0;
    tick();
    chk("t6_idle_after_rst", 32'(wack), 0);
    wreq = 1'b1;
    tick();
    chk("t6_regrant_after_rst", 32'(wack), 1);
    wreq = 1'b0;
    tick();
    wptr = 11'h401;
    tick();
    chk("t6_corrupt_err", 32'(err), 1);
    chk("t6_corrupt_wfull", 32'(wfull), 1);
    wreq = 1'b1;
    wptr = 11'h000;
    tick();
    chk("t6_corrupt_nowack", 32'(wack), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
